// File: rtl/eth_tg_pkg.sv
// Shared beat layout and helpers for the Ethernet traffic generator/checker.
// A beat is {port, pkt_seq, widx, pkt_seq[15:0] ^ A5A5}, so every word identifies itself.
package eth_tg_pkg;

  localparam int DATA_W  = 64;
  localparam int EMPTY_W = 3;
  localparam int SEQ_LSB = 32;
  localparam int SEQ_W   = 24;
  localparam logic [15:0] CHK_KEY = 16'hA5A5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef struct packed {
    logic [7:0]  port;
    logic [23:0] seq;
    logic [15:0] widx;
    logic [15:0] chk;
  } beat_t;

  function automatic logic [DATA_W-1:0] make_beat(input logic [7:0] port,
                                                  input logic [23:0] seq,
                                                  input logic [15:0] widx);
    beat_t b;
    b.port = port;
    b.seq  = seq;
    b.widx = widx;
    b.chk  = seq[15:0] ^ CHK_KEY;
    return b;
  endfunction

  function automatic logic [EMPTY_W-1:0] exp_empty(input logic [23:0] seq,
                                                   input bit var_empty);
    return var_empty ? seq[2:0] : '0;
  endfunction

endpackage

// File: rtl/eth_tg_lane.sv
// One port: packet generator FSM, in-order checker with sop resync, and packet counters.
// The error strobe is combinational so the top can aggregate all lanes in one cycle.
module eth_tg_lane
  import eth_tg_pkg::*;
#(
  parameter int PORT      = 0,
  parameter int PKT_WORDS = 8,
  parameter int PKT_LIMIT = 10000,
  parameter int VAR_EMPTY = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_ok,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_valid,
  output logic               tx_sop,
  output logic               tx_eop,
  output logic [EMPTY_W-1:0] tx_empty,
  input  logic               tx_ready,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic               rx_valid,
  input  logic               rx_sop,
  input  logic               rx_eop,
  input  logic [EMPTY_W-1:0] rx_empty,
  input  logic               rx_ready,
  output logic [31:0]        pkts_sent,
  output logic [31:0]        pkts_rcvd,
  output logic               err,
  output logic [23:0]        err_seq
);

  localparam logic [15:0] LAST_IDX  = 16'(PKT_WORDS - 1);
  localparam logic [7:0]  PORT_ID   = 8'(PORT);
  localparam logic [31:0] LIMIT     = 32'(PKT_LIMIT);
  localparam bit          UNLIMITED = (PKT_LIMIT == 0);
  localparam bit          VAR_E     = (VAR_EMPTY != 0);

  logic [0:0]  state;
  logic [15:0] tx_widx;
  logic [23:0] tx_seq;
  logic        tx_fire;
  logic        tx_last;
  logic        more_ok;

  assign tx_valid = (state == ST_SEND);
  assign tx_sop   = tx_valid && (tx_widx == 16'd0);
  assign tx_eop   = tx_valid && (tx_widx == LAST_IDX);
  assign tx_data  = make_beat(PORT_ID, tx_seq, tx_widx);
  assign tx_empty = tx_eop ? exp_empty(tx_seq, VAR_E) : '0;
  assign tx_fire  = tx_valid && tx_ready;
  assign tx_last  = tx_fire && tx_eop;
  // On the eop cycle the limit is judged against the count after this packet.
  assign more_ok  = start_ok &&
                    (UNLIMITED || ((tx_last ? pkts_sent + 32'd1 : pkts_sent) < LIMIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx_widx   <= '0;
      tx_seq    <= '0;
      pkts_sent <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (more_ok) begin
            state   <= ST_SEND;
            tx_widx <= '0;
          end
        end
        ST_SEND: begin
          if (tx_fire) begin
            if (tx_eop) begin
              pkts_sent <= pkts_sent + 32'd1;
              tx_seq    <= tx_seq + 24'd1;
              tx_widx   <= '0;
              state     <= more_ok ? ST_SEND : ST_IDLE;
            end else begin
              tx_widx <= tx_widx + 16'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [15:0]       rx_widx;
  logic [23:0]       rx_seq;
  logic              dropping;
  logic              resync;
  logic              check;
  logic              bad;
  logic [23:0]       seq_use;
  logic [15:0]       widx_use;
  logic [DATA_W-1:0] exp_data;

  // After an error, beats are discarded until a sop, whose seq field is adopted.
  assign resync   = dropping && rx_sop;
  assign check    = rx_valid && rx_ready && (!dropping || rx_sop);
  assign seq_use  = resync ? rx_data[SEQ_LSB +: SEQ_W] : rx_seq;
  assign widx_use = resync ? 16'd0 : rx_widx;
  assign exp_data = make_beat(PORT_ID, seq_use, widx_use);
  assign bad      = (rx_data != exp_data) ||
                    (rx_sop != (widx_use == 16'd0)) ||
                    (rx_eop != (widx_use == LAST_IDX)) ||
                    (rx_eop && (rx_empty != exp_empty(seq_use, VAR_E)));
  assign err      = check && bad;
  assign err_seq  = seq_use;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_widx   <= '0;
      rx_seq    <= '0;
      dropping  <= 1'b0;
      pkts_rcvd <= '0;
    end else if (check) begin
      if (bad) begin
        dropping <= 1'b1;
      end else begin
        dropping <= 1'b0;
        if (widx_use == LAST_IDX) begin
          pkts_rcvd <= pkts_rcvd + 32'd1;
          rx_seq    <= seq_use + 24'd1;
          rx_widx   <= '0;
        end else begin
          rx_seq  <= seq_use;
          rx_widx <= widx_use + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_traffic_gen_checker.sv
// Multi-port Ethernet traffic source and scoreboard: per-port lanes plus shared xoff holdoff,
// backpressure LFSR, error aggregation, outstanding-packet high-water mark and done flag.
module eth_traffic_gen_checker
  import eth_tg_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          PKT_WORDS = 8,
  parameter int          PKT_LIMIT = 10000,
  parameter int          HOLDOFF   = 1023,
  parameter int          VAR_EMPTY = 0,
  parameter int          BP_MODE   = 1,
  parameter logic [31:0] LFSR_SEED = 32'h1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     xoff,
  output logic [NCH*DATA_W-1:0]    tx_data,
  output logic [NCH-1:0]           tx_valid,
  output logic [NCH-1:0]           tx_sop,
  output logic [NCH-1:0]           tx_eop,
  output logic [NCH*EMPTY_W-1:0]   tx_empty,
  input  logic [NCH-1:0]           tx_ready,
  input  logic [NCH*DATA_W-1:0]    rx_data,
  input  logic [NCH-1:0]           rx_valid,
  input  logic [NCH-1:0]           rx_sop,
  input  logic [NCH-1:0]           rx_eop,
  input  logic [NCH*EMPTY_W-1:0]   rx_empty,
  output logic [NCH-1:0]           rx_ready,
  output logic [NCH*32-1:0]        pkts_sent,
  output logic [NCH*32-1:0]        pkts_rcvd,
  output logic [15:0]              err_count,
  output logic                     err_flag,
  output logic [31:0]              first_err_info,
  output logic [31:0]              max_outstanding,
  output logic                     done
);

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [31:0] HOLD_LOAD = 32'(HOLDOFF);
  localparam logic [31:0] LIMIT     = 32'(PKT_LIMIT);

  logic        xoff_q;
  logic        xoff_rise;
  logic [31:0] holdoff;
  logic [31:0] lfsr;
  logic        start_ok;
  logic [NCH-1:0] lane_err;
  logic [23:0] lane_seq [NCH];

  // The rising-edge cycle itself also blocks new packets, so no sop slips in alongside xoff.
  assign xoff_rise = xoff && !xoff_q;
  assign start_ok  = enable && (holdoff == 32'd0) && !xoff_rise;

  for (genvar p = 0; p < NCH; p++) begin : g_lane
    assign rx_ready[p] = !reset && ((BP_MODE == 0) || (lfsr[3*p +: 5] != 5'd0));

    eth_tg_lane #(
      .PORT      (p),
      .PKT_WORDS (PKT_WORDS),
      .PKT_LIMIT (PKT_LIMIT),
      .VAR_EMPTY (VAR_EMPTY)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .start_ok  (start_ok),
      .tx_data   (tx_data[p*DATA_W +: DATA_W]),
      .tx_valid  (tx_valid[p]),
      .tx_sop    (tx_sop[p]),
      .tx_eop    (tx_eop[p]),
      .tx_empty  (tx_empty[p*EMPTY_W +: EMPTY_W]),
      .tx_ready  (tx_ready[p]),
      .rx_data   (rx_data[p*DATA_W +: DATA_W]),
      .rx_valid  (rx_valid[p]),
      .rx_sop    (rx_sop[p]),
      .rx_eop    (rx_eop[p]),
      .rx_empty  (rx_empty[p*EMPTY_W +: EMPTY_W]),
      .rx_ready  (rx_ready[p]),
      .pkts_sent (pkts_sent[p*32 +: 32]),
      .pkts_rcvd (pkts_rcvd[p*32 +: 32]),
      .err       (lane_err[p]),
      .err_seq   (lane_seq[p])
    );
  end

  logic [3:0]  n_err;
  logic [16:0] err_sum;
  logic [7:0]  first_port;
  logic [23:0] first_seq;
  logic [31:0] diff;
  logic [31:0] cur_max;
  logic        all_done;

  always_comb begin
    n_err      = '0;
    first_port = '0;
    first_seq  = '0;
    diff       = '0;
    cur_max    = '0;
    all_done   = (PKT_LIMIT != 0);
    // Descending scan leaves the lowest erroring port as the reported one.
    for (int p = NCH - 1; p >= 0; p--) begin
      if (lane_err[p]) begin
        first_port = 8'(p);
        first_seq  = lane_seq[p];
      end
    end
    for (int p = 0; p < NCH; p++) begin
      n_err = n_err + 4'(lane_err[p]);
      diff  = pkts_sent[p*32 +: 32] - pkts_rcvd[p*32 +: 32];
      if (diff > cur_max) cur_max = diff;
      if ((pkts_sent[p*32 +: 32] != LIMIT) || (pkts_rcvd[p*32 +: 32] != pkts_sent[p*32 +: 32]))
        all_done = 1'b0;
    end
  end

  assign err_sum = {1'b0, err_count} + 17'(n_err);

  always_ff @(posedge clock) begin
    if (reset) begin
      xoff_q          <= 1'b0;
      holdoff         <= '0;
      lfsr            <= LFSR_SEED;
      err_count       <= '0;
      err_flag        <= 1'b0;
      first_err_info  <= '0;
      max_outstanding <= '0;
      done            <= 1'b0;
    end else begin
      xoff_q <= xoff;
      if (xoff_rise)
        holdoff <= HOLD_LOAD;
      else if (holdoff != 32'd0)
        holdoff <= holdoff - 32'd1;
      lfsr      <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (|lane_err) begin
        err_flag <= 1'b1;
        if (!err_flag) first_err_info <= {first_port, first_seq};
      end
      if (cur_max > max_outstanding) max_outstanding <= cur_max;
      done <= all_done;
    end
  end

endmodule

// File: tb/tb_eth_traffic_gen_checker.sv
// Loopback bench: tx fed back to rx with optional bit-flip/packet-drop injection on port 0,
// covering clean completion, error capture and resync, xoff holdoff/reload and mid-packet reset.
module tb_eth_traffic_gen_checker;

  localparam int NCH       = 2;
  localparam int PKT_WORDS = 8;
  localparam int PKT_LIMIT = 12;
  localparam int HOLDOFF   = 50;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic xoff;
  logic [NCH*64-1:0] tx_data;
  logic [NCH-1:0]    tx_valid, tx_sop, tx_eop, tx_ready;
  logic [NCH*3-1:0]  tx_empty;
  logic [NCH*64-1:0] rx_data;
  logic [NCH-1:0]    rx_valid, rx_sop, rx_eop, rx_ready;
  logic [NCH*3-1:0]  rx_empty;
  logic [NCH*32-1:0] pkts_sent, pkts_rcvd;
  logic [15:0]       err_count;
  logic              err_flag;
  logic [31:0]       first_err_info, max_outstanding;
  logic              done;

  logic inject_flip = 1'b0;
  logic inject_drop = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   beats0 = 0;
  logic [2:0] empty5 = 3'd7;

  always #5 clock = ~clock;

  eth_traffic_gen_checker #(
    .NCH(NCH), .PKT_WORDS(PKT_WORDS), .PKT_LIMIT(PKT_LIMIT), .HOLDOFF(HOLDOFF),
    .VAR_EMPTY(1), .BP_MODE(1), .LFSR_SEED(32'h1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .xoff(xoff),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_empty(tx_empty), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_empty(rx_empty), .rx_ready(rx_ready),
    .pkts_sent(pkts_sent), .pkts_rcvd(pkts_rcvd), .err_count(err_count),
    .err_flag(err_flag), .first_err_info(first_err_info),
    .max_outstanding(max_outstanding), .done(done)
  );

  assign tx_ready = rx_ready;

  always_comb begin
    rx_data  = tx_data;
    rx_valid = tx_valid;
    rx_sop   = tx_sop;
    rx_eop   = tx_eop;
    rx_empty = tx_empty;
    if (inject_flip && tx_data[55:32] == 24'd2 && tx_data[31:16] == 16'd5)
      rx_data[0] = ~tx_data[0];
    if (inject_drop && tx_data[55:32] == 24'd7)
      rx_valid[0] = 1'b0;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && tx_valid[0] && tx_ready[0]) begin
      beats0 <= beats0 + 1;
      if (tx_eop[0] && tx_data[55:32] == 24'd5) empty5 <= tx_empty[2:0];
    end
  end

  task automatic applyStimulus(input logic rst, input logic en, input logic xo);
    reset  = rst;
    enable = en;
    xoff   = xo;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  int n, b0, c1, c2, gap, fin_at;
  logic [23:0] s0, s1;

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("rst_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("rst_rx_ready", 64'(rx_ready), 64'd0);
    checkOutput("rst_pkts_sent", 64'(pkts_sent), 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    checkOutput("rst_first_err", 64'(first_err_info), 64'd0);
    checkOutput("rst_max_out", 64'(max_outstanding), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);

    // Clean loopback run to completion.
    b0 = beats0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while (!(pkts_rcvd[31:0] == 32'd12 && pkts_rcvd[63:32] == 32'd12) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("clean_timeout", 64'(n < 5000), 64'd1);
    checkOutput("done_latency", 64'(done), 64'd0);
    @(negedge clock);
    checkOutput("clean_done", 64'(done), 64'd1);
    checkOutput("clean_sent0", 64'(pkts_sent[31:0]), 64'd12);
    checkOutput("clean_sent1", 64'(pkts_sent[63:32]), 64'd12);
    checkOutput("clean_rcvd1", 64'(pkts_rcvd[63:32]), 64'd12);
    checkOutput("clean_beats0", 64'(beats0 - b0), 64'd96);
    checkOutput("clean_err_count", 64'(err_count), 64'd0);
    checkOutput("clean_err_flag", 64'(err_flag), 64'd0);
    checkOutput("clean_max_out", 64'(max_outstanding), 64'd0);
    checkOutput("var_empty_seq5", 64'(empty5), 64'd5);

    // Bit flip in seq 2 beat 5 and a dropped seq 7 on port 0.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    inject_flip = 1'b1;
    inject_drop = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while (!err_flag && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("err_timeout", 64'(n < 2000), 64'd1);
    checkOutput("first_err_count", 64'(err_count), 64'd1);
    checkOutput("first_err_info", 64'(first_err_info), {32'd0, 8'd0, 24'd2});
    n = 0;
    while (!(pkts_sent[31:0] == 32'd12 && pkts_sent[63:32] == 32'd12) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("err_run_timeout", 64'(n < 5000), 64'd1);
    repeat (3) @(negedge clock);
    checkOutput("err_rcvd0", 64'(pkts_rcvd[31:0]), 64'd9);
    checkOutput("err_rcvd1", 64'(pkts_rcvd[63:32]), 64'd12);
    checkOutput("err_total", 64'(err_count), 64'd2);
    checkOutput("err_flag", 64'(err_flag), 64'd1);
    checkOutput("err_info_kept", 64'(first_err_info), {32'd0, 8'd0, 24'd2});
    checkOutput("err_max_out", 64'(max_outstanding), 64'd3);
    checkOutput("err_done", 64'(done), 64'd0);

    // Single xoff pulse while port 0 is mid-packet.
    inject_flip = 1'b0;
    inject_drop = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while (!(tx_valid[0] && tx_data[31:16] == 16'd3) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("widx3_timeout", 64'(n < 2000), 64'd1);
    s0 = tx_data[55:32];
    xoff = 1'b1;
    @(negedge clock);
    c1 = cyc;
    xoff = 1'b0;
    fin_at = -1;
    n = 0;
    while (!(tx_valid[0] && tx_sop[0] && tx_data[55:32] == s0 + 24'd1) && n < 500) begin
      if (fin_at < 0 && pkts_sent[31:0] == 32'(s0) + 32'd1) fin_at = cyc - c1;
      @(negedge clock);
      n++;
    end
    gap = cyc - c1;
    checkOutput("inflight_finished", 64'(fin_at >= 0 && fin_at < HOLDOFF), 64'd1);
    checkOutput($sformatf("holdoff_gap_%0d", gap),
                64'(gap >= HOLDOFF && gap <= HOLDOFF + 2), 64'd1);

    // Second pulse during holdoff reloads the counter.
    n = 0;
    while (!(tx_valid[0] && tx_data[31:16] == 16'd3) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("widx3b_timeout", 64'(n < 2000), 64'd1);
    s1 = tx_data[55:32];
    xoff = 1'b1;
    @(negedge clock);
    xoff = 1'b0;
    repeat (20) @(negedge clock);
    xoff = 1'b1;
    @(negedge clock);
    c2 = cyc;
    xoff = 1'b0;
    n = 0;
    while (!(tx_valid[0] && tx_sop[0] && tx_data[55:32] == s1 + 24'd1) && n < 500) begin
      @(negedge clock);
      n++;
    end
    gap = cyc - c2;
    checkOutput($sformatf("reload_gap_%0d", gap),
                64'(gap >= HOLDOFF && gap <= HOLDOFF + 2), 64'd1);

    // Reset in the middle of a packet, then restart from seq 0.
    n = 0;
    while (!(tx_valid[0] && tx_data[31:16] == 16'd4) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("widx4_timeout", 64'(n < 2000), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("midrst_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("midrst_rx_ready", 64'(rx_ready), 64'd0);
    checkOutput("midrst_sent", 64'(pkts_sent), 64'd0);
    checkOutput("midrst_rcvd", 64'(pkts_rcvd), 64'd0);
    checkOutput("midrst_max_out", 64'(max_outstanding), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("restart_valid", 64'(tx_valid[0]), 64'd1);
    checkOutput("restart_sop", 64'(tx_sop[0]), 64'd1);
    checkOutput("restart_beat0", tx_data[63:0], 64'h00_000000_0000_A5A5);
    checkOutput("restart_beat1", tx_data[127:64], 64'h01_000000_0000_A5A5);
    n = 0;
    while (pkts_rcvd[31:0] < 32'd2 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("restart_timeout", 64'(n < 2000), 64'd1);
    checkOutput("restart_err_count", 64'(err_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
